// File: rtl/note_sequencer.sv
// Note recorder/player: captures note codes on load_n releases and plays them
// back one per STEP_TICKS clock cycles, optionally looping.
//
// state  | meaning
// IDLE   | waiting for record strobe, playback start or clear
// RECORD | load_n held low; note captured on release
// PLAY   | stepping through recorded notes
module note_sequencer #(
  parameter int NOTE_W     = 4,
  parameter int DEPTH      = 16,
  parameter int STEP_TICKS = 25000000,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_n,
  input  logic              playback_n,
  input  logic              stop,
  input  logic              loop,
  input  logic              clear,
  input  logic [NOTE_W-1:0] note_in,
  output logic              ld_note,
  output logic              ld_play,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic [AW-1:0]     note_counter,
  output logic [AW:0]       notes_recorded,
  output logic              full,
  output logic              step_tick
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECORD = 2'd1;
  localparam logic [1:0] PLAY   = 2'd2;

  localparam int          TW          = $clog2(STEP_TICKS);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(STEP_TICKS - 1);

  logic [1:0]        state;
  logic [TW-1:0]     tick_cnt;
  logic [NOTE_W-1:0] mem [DEPTH];
  logic [AW:0]       last_idx;
  logic              last_note;
  logic              mem_we;

  assign full       = (notes_recorded == (AW+1)'(DEPTH));
  assign ld_note    = (state == RECORD);
  assign ld_play    = (state == PLAY);
  assign note_valid = (state == PLAY);
  assign step_tick  = (state == PLAY) && (tick_cnt == '0);
  assign note_out   = (state == PLAY) ? mem[note_counter] : '0;
  assign last_idx   = notes_recorded - (AW+1)'(1);
  assign last_note  = ({1'b0, note_counter} == last_idx);
  assign mem_we     = !reset && (state == RECORD) && load_n && !full;

  // Memory is deliberately left out of reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[notes_recorded[AW-1:0]] <= note_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      note_counter   <= '0;
      notes_recorded <= '0;
      tick_cnt       <= TICK_RELOAD;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            notes_recorded <= '0;
          end
          if (!load_n) begin
            state <= RECORD;
          end else if (!playback_n && !clear && (notes_recorded != '0)) begin
            state        <= PLAY;
            note_counter <= '0;
            tick_cnt     <= TICK_RELOAD;
          end
        end
        RECORD: begin
          if (load_n) begin
            if (!full) begin
              notes_recorded <= notes_recorded + (AW+1)'(1);
            end
            state <= IDLE;
          end
        end
        PLAY: begin
          // stop wins over a coincident step boundary
          if (stop) begin
            state        <= IDLE;
            note_counter <= '0;
            tick_cnt     <= TICK_RELOAD;
          end else if (step_tick) begin
            tick_cnt <= TICK_RELOAD;
            if (last_note) begin
              note_counter <= '0;
              if (!loop) begin
                state <= IDLE;
              end
            end else begin
              note_counter <= note_counter + AW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt - TW'(1);
          end
        end
        default: begin
          state        <= IDLE;
          note_counter <= '0;
          tick_cnt     <= TICK_RELOAD;
        end
      endcase
    end
  end

endmodule
